arb_rr_lock: RTL

- Parametrised N-requester arbiter; next generation of the 4-input fixed-priority logic.
- Adds a clock and a registered one-hot grant with hold-until-release locking.
- Runtime-selectable fixed-priority or round-robin mode; also outputs an encoded grant index.
- Sits between bus requesters and the shared-resource mux; gnt_id drives the mux select.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/arb_pick.sv | 50 +++++
 rtl/arb_rr_lock.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the lockable round-robin / fixed-priority arbiter.
// Contents:
//   ARB_FIXED, ARB_RR  - values of the runtime mode input
//   arb_state_t        - arbiter FSM state encoding
//   onehot_to_idx      - binary index of the set bit of a one-hot vector (up to 32 bits)
package arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // OR-reduce the indices of the set bits. For a one-hot or zero input, this
    // gives the exact index, or 0 when the input is zero.
    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker for the arbiter.
// Ports:
//   req     in  N   request vector
//   mask    in  N   eligibility mask (1 = may win)
//   ptr     in  IW  index of the last winner; the RR search starts at ptr+1
//   mode    in  1   ARB_FIXED (lowest index wins) or ARB_RR
//   win     out N   one-hot winner, zero when nothing is eligible
//   any_hit out 1   at least one eligible request
module arb_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  win,
    output logic          any_hit
);

    logic [N-1:0]   elig;
    logic [IW:0]    start;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_first;
    logic [2*N-1:0] dbl_oh;
    logic [N-1:0]   rr_win;
    logic [N-1:0]   fx_win;

    always_comb begin
        elig    = req & mask;
        any_hit = |elig;

        // Rotate the eligible vector so index ptr+1 lands at bit 0, take the
        // lowest set bit, then rotate the one-hot result back into place.
        start     = {1'b0, ptr} + {{IW{1'b0}}, 1'b1};
        dbl       = {elig, elig} >> start;
        rot       = dbl[N-1:0];
        rot_first = rot & (~rot + N'(1));
        dbl_oh    = {rot_first, rot_first} << start;
        rr_win    = dbl_oh[2*N-1:N];

        fx_win    = elig & (~elig + N'(1));

        win = (mode == ARB_RR) ? rr_win : fx_win;
    end

endmodule

// File: rtl/arb_rr_lock.sv
// N-requester arbiter with a registered one-hot grant. The grant is held
// until the owner releases its request. Selection is fixed-priority or
// round-robin, chosen at runtime. gnt_id drives the shared-resource mux select.
//
// Optional build macro ARB_HOLD_LIMIT_EN: after MAX_HOLD locked cycles, the
// owner is forced off the grant whenever another requester is waiting.
//
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   synchronous active-low reset
//   enable    in  1   arbitration enable; 0 clears the grant
//   mode      in  1   0 = fixed priority (index 0 highest), 1 = round-robin
//   req       in  N   level-sensitive requests
//   gnt       out N   registered one-hot grant
//   gnt_id    out IW  binary index of the granted requester
//   gnt_valid out 1   grant is nonzero
//
// state     | meaning
// ----------+----------------------------------------------------------
// ARB_IDLE  | no owner; arbitrate whenever any request is present
// ARB_GRANT | gnt_q holds the owner; re-arbitrate only on release
//           | (or when the hold limit expires, if that feature is built)
module arb_rr_lock
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          mode,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid
);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] ptr_q;
    logic [N-1:0]  mask;
    logic [N-1:0]  win;
    logic [IW-1:0] win_idx;
    logic          any_hit;
    logic          do_arb;
    logic          new_grant;
    logic          owner_req;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt_q;
`endif

    arb_pick #(.N(N), .IW(IW)) u_pick (
        .req     (req),
        .mask    (mask),
        .ptr     (ptr_q),
        .mode    (mode),
        .win     (win),
        .any_hit (any_hit)
    );

    assign win_idx = IW'(onehot_to_idx(32'(win)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= IW'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (new_grant) ptr_q <= win_idx;
`ifdef ARB_HOLD_LIMIT_EN
            // Saturate at MAX_HOLD-1 so that a late-arriving requester
            // forces the handover at the very next edge.
            if (new_grant)
                cnt_q <= '0;
            else if (enable && state_q == ARB_GRANT && cnt_q != CW'(MAX_HOLD - 1))
                cnt_q <= cnt_q + CW'(1);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        mask      = '1;
        do_arb    = 1'b0;
        new_grant = 1'b0;
        owner_req = |(req & gnt_q);

        if (!enable) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
        end else begin
            case (state_q)
                ARB_IDLE: do_arb = 1'b1;
                ARB_GRANT: begin
                    if (!owner_req) begin
                        do_arb = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    end else if (cnt_q == CW'(MAX_HOLD - 1) && |(req & ~gnt_q)) begin
                        do_arb = 1'b1;
                        mask   = ~gnt_q;
`endif
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            endcase

            if (do_arb) begin
                if (any_hit) begin
                    state_d   = ARB_GRANT;
                    gnt_d     = win;
                    new_grant = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
        end
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_id    = IW'(onehot_to_idx(32'(gnt_q)));
        gnt_valid = |gnt_q;
    end

endmodule
